serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares a single `full_adder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. Sits between a requester, which supplies operands with a start pulse, and the one-bit adder datapath. The block sequences operand shifting, carry feedback and result assembly, then reports completion with a done pulse. It trades latency for area and replaces a WIDTH-bit ripple adder where throughput is not critical.

---
 rtl/serial_add_ctrl_pkg.sv | 18 +
 rtl/serial_add_ctrl_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_serial_add_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding, default width
// and the bit-counter sizing helper.
package serial_add_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell, time-shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one full_adder,
// one bit per clock, and pulses done when {co, sum} = a + b + ci is complete.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fa_s, fa_co;

    full_adder u_full_adder (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    sum_d   = '0;
                    co_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // Result bits enter from the MSB so bit k lands in place after WIDTH shifts.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                carry_d          = fa_co;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    co_d    = fa_co;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table, multi-cycle corner cases
// and randomized operands against a plain-arithmetic reference.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0;
    logic       busy8, done8, co8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ci1 = 1'b0;
    logic       busy1, done1, co1;
    logic [0:0] sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ci    (ci8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .co    (co8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_sum;
        logic       exp_co;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation, waits for done (bounded) and reports result, latency and the
    // number of cycles busy was seen high. Returns just after the edge that raised done.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input bit scramble, output logic [7:0] s, output logic c,
                         output int lat, output int busy_cycles);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        ci8 = ci;
        tick();
        start8 = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cycles++;
            if (scramble) begin
                a8  = 8'($urandom);
                b8  = 8'($urandom);
                ci8 = 1'($urandom);
            end
            tick();
            lat++;
        end
        if (lat >= 40) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no done expected done within 8 cycles");
        end
        s = sum8;
        c = co8;
    endtask

    logic [7:0] s;
    logic       c;
    int         lat, bc;
    logic [8:0] model;

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy8), 0);
        check("reset_done", 32'(done8), 0);
        check("reset_sum", 32'(sum8), 0);
        check("reset_co", 32'(co8), 0);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, s, c, lat, bc);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_co", i), 32'(c), 32'(vecs[i].exp_co));
            check($sformatf("vec%0d_latency", i), 32'(lat), 8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 8);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done8), 0);
            check($sformatf("vec%0d_sum_hold", i), 32'(sum8), 32'(vecs[i].exp_sum));
        end

        // start held high: RUN-time request ignored, DONE-cycle request accepted back-to-back
        start8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
        ci8 = 1'b0;
        tick();
        a8 = 8'h10;
        b8 = 8'h20;
        lat = 0;
        while (!done8 && lat < 40) begin tick(); lat++; end
        check("hold_first_sum", 32'(sum8), 32'h03);
        check("hold_first_latency", 32'(lat), 8);
        lat = 0;
        tick();
        check("hold_b2b_busy", 32'(busy8), 1);
        while (!done8 && lat < 40) begin tick(); lat++; end
        check("hold_done_spacing", 32'(lat + 1), 9);
        check("hold_second_sum", 32'(sum8), 32'h30);
        start8 = 1'b0;
        tick();
        check("hold_idle_after", 32'(busy8 | done8), 0);

        // Reset on the 4th RUN cycle discards the operation
        start8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h3C;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_busy_before", 32'(busy8), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy8), 0);
        check("rst_mid_sum", 32'(sum8), 0);
        check("rst_mid_co", 32'(co8), 0);
        check("rst_mid_done", 32'(done8), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8) check("rst_mid_no_done", 32'(done8), 0);
        end
        do_op(8'h01, 8'h01, 1'b0, 1'b0, s, c, lat, bc);
        check("post_rst_sum", 32'(s), 32'h02);
        tick();

        // Reset coincident with start wins
        rst = 1'b1;
        start8 = 1'b1;
        tick();
        rst = 1'b0;
        start8 = 1'b0;
        check("rst_vs_start_busy", 32'(busy8), 0);

        // Randomized operands, changed every cycle after accept, against plain arithmetic
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            do_op(ra, rb, rc, 1'b1, s, c, lat, bc);
            check($sformatf("rand%0d_result", i), 32'({c, s}), 32'(model));
            check($sformatf("rand%0d_latency", i), 32'(lat), 8);
            if (i % 2 == 0) tick();
        end

        // WIDTH=1 instance
        tick();
        start1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        ci1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1 = 1'b0;
        b1 = 1'b0;
        ci1 = 1'b0;
        check("w1_busy", 32'(busy1), 1);
        check("w1_done_early", 32'(done1), 0);
        tick();
        check("w1_done", 32'(done1), 1);
        check("w1_busy_off", 32'(busy1), 0);
        check("w1_sum", 32'(sum1), 1);
        check("w1_co", 32'(co1), 1);
        tick();
        check("w1_done_pulse", 32'(done1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
